onchip_mem_copy_master: RTL and testbench

ONCHIP_MEM_COPY_MASTER -- requirements
Module: onchip_mem_copy_master

---
 rtl/onchip_mem_copy_master.sv | 246 ++++++++++++++++++++++++
 tb/tb_onchip_mem_copy_master.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_copy_master.sv
// ----------------------------------------------------------------------------
// onchip_mem_copy_master
//
// Word-granular memory-to-memory copy engine controlled through a small CSR
// block. Software programs SRC, DST and LEN, then writes GO. The engine walks
// the source region in ascending order, reading one word, waiting one cycle
// for the fixed-latency read data, then writing it to the destination. Each
// word therefore costs exactly three cycles (RD, WT, WR); one FIN cycle
// follows the last word to raise DONE.
//
// Ports
//   clk            single clock, rising edge
//   reset_n        synchronous active-low reset
//   csr_address    CSR word select: 0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS
//   csr_write      CSR write strobe
//   csr_read       CSR read strobe
//   csr_writedata  CSR write data
//   csr_readdata   registered CSR read data, valid the cycle after csr_read
//   irq            level interrupt, DONE & IRQ_EN
//   m_address      word address to the memory slave
//   m_chipselect   memory select
//   m_write        write enable, qualified by m_chipselect
//   m_byteenable   all lanes while selected, otherwise zero
//   m_writedata    write data
//   m_readdata     read data, valid one cycle after the read address
//
// CTRL write: bit0 GO, bit1 IRQ_EN, bit2 DONE_CLR (write-1-clear).
// STATUS read: bit0 BUSY, bit1 IRQ_EN, bit2 DONE, [16 +: LEN_W] words left.
// ----------------------------------------------------------------------------
module onchip_mem_copy_master #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata
);

    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  CntOne  = LEN_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWt,
        StWr,
        StFin
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e             state_q, state_d;

    // Programmed registers
    logic [ADDR_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0]  dst_q, dst_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               irq_en_q, irq_en_d;
    logic               done_q, done_d;

    // Working copies advanced by the engine
    logic [ADDR_W-1:0]  wsrc_q, wsrc_d;
    logic [ADDR_W-1:0]  wdst_q, wdst_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        data_q, data_d;

    logic [31:0]        csr_readdata_q, csr_readdata_d;

    // ------------------------------------------------------------------------
    // CSR decode
    // ------------------------------------------------------------------------
    logic        busy;
    logic        wr_src;
    logic        wr_dst;
    logic        wr_len;
    logic        wr_ctrl;
    logic        go;
    logic [31:0] status_word;
    logic        unused_wdata;

    // Upper write-data bits are not stored anywhere; fold them away.
    assign unused_wdata = ^csr_writedata;

    always_comb begin
        busy    = (state_q != StIdle);
        // Address/length registers are frozen while a copy is in flight.
        wr_src  = csr_write && (csr_address == 2'd0) && !busy;
        wr_dst  = csr_write && (csr_address == 2'd1) && !busy;
        wr_len  = csr_write && (csr_address == 2'd2) && !busy;
        wr_ctrl = csr_write && (csr_address == 2'd3);
        go      = wr_ctrl && csr_writedata[0] && !busy;

        status_word              = '0;
        status_word[0]           = busy;
        status_word[1]           = irq_en_q;
        status_word[2]           = done_q;
        status_word[16 +: LEN_W] = cnt_q;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        dst_d          = dst_q;
        len_d          = len_q;
        irq_en_d       = irq_en_q;
        done_d         = done_q;
        wsrc_d         = wsrc_q;
        wdst_d         = wdst_q;
        cnt_d          = cnt_q;
        data_d         = data_q;
        csr_readdata_d = csr_readdata_q;

        if (wr_src) begin
            src_d = csr_writedata[ADDR_W-1:0];
        end
        if (wr_dst) begin
            dst_d = csr_writedata[ADDR_W-1:0];
        end
        if (wr_len) begin
            len_d = csr_writedata[LEN_W-1:0];
        end
        if (wr_ctrl) begin
            irq_en_d = csr_writedata[1];
            if (csr_writedata[2]) begin
                done_d = 1'b0;
            end
        end

        // Assigned after DONE_CLR so that FIN setting DONE takes priority.
        case (state_q)
            StIdle: begin
                if (go) begin
                    done_d  = 1'b0;
                    wsrc_d  = src_q;
                    wdst_d  = dst_q;
                    cnt_d   = len_q;
                    state_d = (len_q == '0) ? StFin : StRd;
                end
            end
            StRd: begin
                state_d = StWt;
            end
            StWt: begin
                // Read data arrives one cycle after the address phase.
                data_d  = m_readdata;
                state_d = StWr;
            end
            StWr: begin
                wsrc_d  = wsrc_q + AddrOne;
                wdst_d  = wdst_q + AddrOne;
                cnt_d   = cnt_q - CntOne;
                state_d = (cnt_q == CntOne) ? StFin : StRd;
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (csr_read) begin
            unique case (csr_address)
                2'd0: csr_readdata_d = 32'(src_q);
                2'd1: csr_readdata_d = 32'(dst_q);
                2'd2: csr_readdata_d = 32'(len_q);
                2'd3: csr_readdata_d = status_word;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            src_q          <= '0;
            dst_q          <= '0;
            len_q          <= '0;
            irq_en_q       <= 1'b0;
            done_q         <= 1'b0;
            wsrc_q         <= '0;
            wdst_q         <= '0;
            cnt_q          <= '0;
            data_q         <= '0;
            csr_readdata_q <= '0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            len_q          <= len_d;
            irq_en_q       <= irq_en_d;
            done_q         <= done_d;
            wsrc_q         <= wsrc_d;
            wdst_q         <= wdst_d;
            cnt_q          <= cnt_d;
            data_q         <= data_d;
            csr_readdata_q <= csr_readdata_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded purely from registered state, so reset forces them low
    // ------------------------------------------------------------------------
    always_comb begin
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_writedata  = '0;
        case (state_q)
            StRd: begin
                m_chipselect = 1'b1;
                m_address    = wsrc_q;
            end
            StWr: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = wdst_q;
                m_writedata  = data_q;
            end
            default: begin
            end
        endcase
        m_byteenable = {4{m_chipselect}};
        irq          = done_q & irq_en_q;
        csr_readdata = csr_readdata_q;
    end

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
module tb_onchip_mem_copy_master;

    localparam int AW    = 10;
    localparam int LW    = 11;
    localparam int MEMSZ = 1024;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    csr_address;
    logic          csr_write;
    logic          csr_read;
    logic [31:0]   csr_writedata;
    logic [31:0]   csr_readdata;
    logic          irq;
    logic [AW-1:0] m_address;
    logic          m_chipselect;
    logic          m_write;
    logic [3:0]    m_byteenable;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata;

    always #5 clk = ~clk;

    onchip_mem_copy_master #(
        .ADDR_W (AW),
        .LEN_W  (LW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .csr_address   (csr_address),
        .csr_write     (csr_write),
        .csr_read      (csr_read),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .irq           (irq),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_byteenable  (m_byteenable),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata)
    );

    // Memory slave with read latency 1; preloaded with a seeded pattern.
    logic [31:0] mem   [MEMSZ];
    logic [31:0] model [MEMSZ];
    logic        reload = 1'b0;
    logic [31:0] seed   = '0;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] fill(int i, logic [31:0] s);
        return s ^ (32'(i) * 32'h9E3779B1) ^ 32'(i);
    endfunction

    always @(posedge clk) begin
        if (reload) begin
            for (int i = 0; i < MEMSZ; i++) mem[i] <= fill(i, seed);
        end else if (m_chipselect) begin
            if (m_write) mem[m_address] <= m_writedata;
            else         m_readdata     <= mem[m_address];
        end
    end

    function automatic logic [47:0] bus_now();
        return {m_chipselect, m_write, m_byteenable, m_address, m_writedata};
    endfunction

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        @(negedge clk);
        csr_write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        @(negedge clk);
        csr_read    = 1'b0;
        d           = csr_readdata;
    endtask

    task automatic load_mem(input logic [31:0] s);
        seed   = s;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        for (int i = 0; i < MEMSZ; i++) model[i] = fill(i, s);
    endtask

    task automatic check_mem(input string name);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int i = 0; i < MEMSZ; i++) begin
            if (mem[i] !== model[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s mem: %0d words differ, first 0x%03h got %08h want %08h",
                     name, bad, first, mem[first], model[first]);
        end
    endtask

    // mode 0: plain copy; 1: SRC write + GO while busy, STATUS polled each cycle;
    // 2: DONE_CLR written in the FIN cycle; 3: reset during WR of the second word.
    task automatic run_transfer(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                input int len, input bit ien, input int mode,
                                input string name);
        logic [31:0]   rd;
        logic [31:0]   pend_exp;
        logic [31:0]   exp_st;
        logic [47:0]   exp_bus;
        logic [AW-1:0] sa;
        logic [AW-1:0] da;
        int            total;
        int            widx;
        int            cnt;
        bit            pend;
        bit            stop;

        csr_wr(2'd0, 32'(src));
        csr_wr(2'd1, 32'(dst));
        csr_wr(2'd2, 32'(len));
        csr_wr(2'd3, {30'b0, ien, 1'b1});

        total    = (len == 0) ? 1 : 3 * len + 1;
        pend     = 1'b0;
        pend_exp = '0;
        stop     = 1'b0;
        for (int k = 0; k < total && !stop; k++) begin
            widx    = k / 3;
            sa      = src + AW'(widx);
            da      = dst + AW'(widx);
            exp_bus = '0;
            if (!(mode == 3 && k == 6) && k < 3 * len) begin
                case (k % 3)
                    0: exp_bus = {1'b1, 1'b0, 4'hF, sa, 32'h0};
                    2: exp_bus = {1'b1, 1'b1, 4'hF, da, model[sa]};
                    default: ;
                endcase
            end
            checks++;
            if (bus_now() !== exp_bus) begin
                errors++;
                $display("FAIL %s bus k=%0d: got %012h want %012h", name, k, bus_now(), exp_bus);
            end
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL %s irq k=%0d: got %b want 0", name, k, irq);
            end
            if (pend) begin
                checks++;
                if (csr_readdata !== pend_exp) begin
                    errors++;
                    $display("FAIL %s status k=%0d: got %08h want %08h",
                             name, k, csr_readdata, pend_exp);
                end
                pend = 1'b0;
            end
            if (!(mode == 3 && k == 6) && k < 3 * len && (k % 3) == 2) model[da] = model[sa];

            csr_write = 1'b0;
            csr_read  = 1'b0;
            if (mode == 3 && k == 5) reset_n = 1'b0;
            if (mode == 3 && k == 6) begin
                checks++;
                if (csr_readdata !== 32'h0) begin
                    errors++;
                    $display("FAIL %s readdata after reset: got %08h want 0", name, csr_readdata);
                end
                reset_n = 1'b1;
                stop    = 1'b1;
            end else if (mode == 1) begin
                if (k == 1) begin
                    csr_address = 2'd0; csr_writedata = 32'h055; csr_write = 1'b1;
                end else if (k == 2) begin
                    csr_address = 2'd3; csr_writedata = 32'h1; csr_write = 1'b1;
                end else if (k >= 3) begin
                    cnt         = (k < 3 * len) ? len - k / 3 : 0;
                    csr_address = 2'd3;
                    csr_read    = 1'b1;
                    pend        = 1'b1;
                    pend_exp    = (32'(cnt) << 16) | 32'h1;
                end
            end else if (mode == 2 && k == total - 1) begin
                csr_address = 2'd3; csr_writedata = 32'h4 | (32'(ien) << 1); csr_write = 1'b1;
            end
            @(negedge clk);
        end
        csr_write = 1'b0;
        csr_read  = 1'b0;

        if (pend) begin
            checks++;
            if (csr_readdata !== pend_exp) begin
                errors++;
                $display("FAIL %s status FIN: got %08h want %08h", name, csr_readdata, pend_exp);
            end
        end

        if (mode == 3) begin
            csr_rd(2'd3, rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL %s status after reset: got %08h want 0", name, rd);
            end
            check_mem(name);
            return;
        end

        exp_st = 32'h4 | (32'(ien) << 1);
        checks++;
        if (bus_now() !== 48'h0) begin
            errors++;
            $display("FAIL %s bus idle: got %012h want 0", name, bus_now());
        end
        checks++;
        if (irq !== ien) begin
            errors++;
            $display("FAIL %s irq done: got %b want %b", name, irq, ien);
        end
        csr_rd(2'd3, rd);
        checks++;
        if (rd !== exp_st) begin
            errors++;
            $display("FAIL %s status done: got %08h want %08h", name, rd, exp_st);
        end
        csr_rd(2'd0, rd);
        checks++;
        if (rd !== 32'(src)) begin
            errors++;
            $display("FAIL %s SRC readback: got %08h want %08h", name, rd, 32'(src));
        end
        checks++;
        if (bus_now() !== 48'h0) begin
            errors++;
            $display("FAIL %s bus after: got %012h want 0", name, bus_now());
        end
        check_mem(name);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_now() !== 48'h0 || irq !== 1'b0 || csr_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs: got bus %012h irq %b rd %08h want all 0",
                     bus_now(), irq, csr_readdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            csr_rd(2'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL reset csr%0d: got %08h want 0", a, rd);
            end
        end
    endtask

    task automatic test_basic();
        load_mem(32'hA5A50000);
        run_transfer(10'h010, 10'h200, 4, 1'b0, 0, "basic");
    endtask

    task automatic test_len_zero();
        logic [31:0] rd;
        load_mem(32'h0BADF00D);
        run_transfer(10'h123, 10'h321, 0, 1'b1, 0, "len0");
        csr_wr(2'd3, 32'h6);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL len0 irq after DONE_CLR: got %b want 0", irq);
        end
        csr_rd(2'd3, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL len0 status after DONE_CLR: got %08h want 00000002", rd);
        end
    endtask

    task automatic test_wrap();
        load_mem(32'h13572468);
        run_transfer(10'h3FE, 10'h100, 3, 1'b0, 0, "wrap");
    endtask

    task automatic test_busy_ignore();
        load_mem(32'hCAFE0001);
        run_transfer(10'h040, 10'h300, 8, 1'b0, 1, "busy_ignore");
    endtask

    task automatic test_done_clr_fin();
        load_mem($urandom);
        run_transfer(10'h0A0, 10'h2A0, 2, 1'b1, 2, "done_clr_fin");
    endtask

    task automatic test_reset_mid();
        load_mem($urandom);
        run_transfer(10'h080, 10'h180, 5, 1'b0, 3, "reset_mid");
    endtask

    task automatic test_random();
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        int            n;
        bit            ien;
        for (int r = 0; r < 6; r++) begin
            if (r != 3) load_mem($urandom);
            s   = AW'($urandom);
            d   = (r == 2) ? s + AW'(1) : AW'($urandom);
            n   = $urandom_range(1, 10);
            ien = 1'($urandom_range(0, 1));
            run_transfer(s, d, n, ien, 0, $sformatf("random%0d", r));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        csr_address   = 2'd0;
        csr_write     = 1'b0;
        csr_read      = 1'b0;
        csr_writedata = 32'h0;
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_busy_ignore();
        test_done_clr_fin();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
